// File: rtl/i2c_reg_pkg.sv
// Shared types and helpers for the i2c_reg_bank register bank.
//   i2c_reg_state_e : byte-level decode state
//   PTR_W           : register pointer width
//   OOR_DATA        : read data returned for an out-of-range pointer
//   next_ptr()      : pointer advance with wrap at num_regs-1
package i2c_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } i2c_reg_state_e;

  localparam int unsigned PTR_W = 8;
  localparam logic [7:0]  OOR_DATA = 8'hFF;

  // The last valid index wraps to 0. An out-of-range pointer keeps
  // counting through 255 and then wraps to 0 through natural overflow.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned      num_regs);
    if (ptr == PTR_W'(num_regs - 1))
      return '0;
    else
      return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/i2c_reg_ptr.sv
// Register pointer for i2c_reg_bank.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (ptr -> 0)
//   load         : load ptr from load_val (pointer byte); has priority
//   load_val     : new pointer value
//   advance      : step the pointer after a data byte
//   ptr          : current register pointer
//   in_range     : ptr < NUM_REGS
// Build option: I2C_REG_AUTOINC_EN enables stepping on advance. Without
// it the pointer holds, so bursts keep addressing the same register.
module i2c_reg_ptr
  import i2c_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  input  logic             advance,
  output logic [PTR_W-1:0] ptr,
  output logic             in_range
);

  logic [PTR_W-1:0] step_ptr;

  always_comb begin
`ifdef I2C_REG_AUTOINC_EN
    step_ptr = next_ptr(ptr, NUM_REGS);
`else
    step_ptr = ptr;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (load)
      ptr <= load_val;
    else if (advance)
      ptr <= step_ptr;
  end

  assign in_range = ({1'b0, ptr} < 9'(NUM_REGS));

endmodule

// File: rtl/i2c_reg_bank.sv
// Parametrised register bank behind the byte-level i2c_slave. Decodes the
// byte-complete handshake into pointer set, burst writes and burst reads.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   sl_start   : START / repeated START pulse
//   sl_stop    : STOP pulse
//   sl_ack     : high during the ACK slot of each data byte
//   sl_r, sl_w : transfer direction (both high is treated as write)
//   sl_rxdata  : byte received from the master
//   sl_txdata  : registered byte presented to the master
//   ro_data    : live values for read-only registers
//   reg_q      : register contents, RO entries mirror ro_data
//   wr_stb     : one-cycle pulse per accepted write
//   wr_addr    : index of the last accepted write
//   err_cnt    : saturating count of rejected writes
// Build option: I2C_REG_AUTOINC_EN enables pointer auto-increment.
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter int unsigned          NUM_REGS     = 4,
  parameter logic [NUM_REGS*8-1:0] RESET_VALUES = {8'd0, 8'd0, 8'd6, 8'd5},
  parameter logic [NUM_REGS-1:0]   RO_MASK      = 4'b0000,
  parameter int unsigned          ERR_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sl_start,
  input  logic                  sl_stop,
  input  logic                  sl_ack,
  input  logic                  sl_r,
  input  logic                  sl_w,
  input  logic [7:0]            sl_rxdata,
  output logic [7:0]            sl_txdata,
  input  logic [NUM_REGS*8-1:0] ro_data,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_stb,
  output logic [7:0]            wr_addr,
  output logic [ERR_W-1:0]      err_cnt
);

  // ro_data is not valid during reset, so an RO reg0 drives zero.
  localparam logic [7:0] TX_RST = RO_MASK[0] ? 8'h00 : RESET_VALUES[7:0];

  i2c_reg_state_e   state_q, state_d;
  logic             ack_d;
  logic             evt;
  logic [7:0]       regs [NUM_REGS];
  logic [PTR_W-1:0] ptr;
  logic             in_range;
  logic             ptr_load, ptr_adv, wr_en, wr_rej;
  logic             cur_ro;
  logic [7:0]       cur_rw_val, cur_ro_val, tx_d;

  assign evt = sl_ack & ~ack_d;

  i2c_reg_ptr #(
    .NUM_REGS (NUM_REGS)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (ptr_load),
    .load_val (sl_rxdata),
    .advance  (ptr_adv),
    .ptr      (ptr),
    .in_range (in_range)
  );

  // Selected-register view; a pointer beyond NUM_REGS matches nothing.
  always_comb begin
    cur_ro     = 1'b0;
    cur_rw_val = '0;
    cur_ro_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ptr == PTR_W'(i)) begin
        cur_ro     = RO_MASK[i];
        cur_rw_val = regs[i];
        cur_ro_val = ro_data[i*8 +: 8];
      end
    end
  end

  // Stop beats start, start beats a byte event (the event is dropped).
  always_comb begin
    state_d  = state_q;
    ptr_load = 1'b0;
    ptr_adv  = 1'b0;
    wr_en    = 1'b0;
    wr_rej   = 1'b0;
    if (sl_stop) begin
      state_d = IDLE;
    end else if (sl_start) begin
      state_d = SEL;
    end else if (evt) begin
      case (state_q)
        SEL: begin
          if (sl_w) begin
            ptr_load = 1'b1;
            state_d  = WDATA;
          end else if (sl_r) begin
            ptr_adv = 1'b1;
            state_d = RDATA;
          end
        end
        WDATA: begin
          ptr_adv = 1'b1;
          if (in_range && !cur_ro)
            wr_en = 1'b1;
          else
            wr_rej = 1'b1;
        end
        RDATA:   ptr_adv = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    if (!in_range)
      tx_d = OOR_DATA;
    else if (cur_ro)
      tx_d = cur_ro_val;
    else
      tx_d = cur_rw_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ack_d     <= 1'b0;
      sl_txdata <= TX_RST;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      ack_d     <= sl_ack;
      sl_txdata <= tx_d;
      wr_stb    <= wr_en;
      if (wr_en)
        wr_addr <= ptr;
      if (wr_rej && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VALUES[i*8 +: 8];
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (ptr == PTR_W'(i))
          regs[i] <= sl_rxdata;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      reg_q[i*8 +: 8] = RO_MASK[i] ? ro_data[i*8 +: 8] : regs[i];
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Scoreboard bench for i2c_reg_bank: the stimulus pushes expected writes and
// read bytes into queues; a monitor pops and compares on each wr_stb pulse
// and on each read sampling point.
module tb_i2c_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        sl_start, sl_stop, sl_ack, sl_r, sl_w;
  logic [7:0]  sl_rxdata, sl_txdata;
  logic [31:0] ro_data, reg_q;
  logic        wr_stb;
  logic [7:0]  wr_addr;
  logic [1:0]  err_cnt;
  logic        rd_sample = 1'b0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  logic [7:0] rd_q[$];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  i2c_reg_bank #(
    .NUM_REGS     (4),
    .RESET_VALUES ({8'd0, 8'd0, 8'd6, 8'd5}),
    .RO_MASK      (4'b0100),
    .ERR_W        (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sl_start  (sl_start),
    .sl_stop   (sl_stop),
    .sl_ack    (sl_ack),
    .sl_r      (sl_r),
    .sl_w      (sl_w),
    .sl_rxdata (sl_rxdata),
    .sl_txdata (sl_txdata),
    .ro_data   (ro_data),
    .reg_q     (reg_q),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_exp_t    e;
    logic [7:0] r;
    int         idx;
    if (wr_stb) begin
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_stb_unexpected actual_addr=%h required=no_pulse", wr_addr);
      end else begin
        e   = wr_q.pop_front();
        idx = int'(e.addr);
        if (wr_addr !== e.addr || reg_q[idx*8 +: 8] !== e.data) begin
          failures++;
          $display("FAIL wr_event actual=%h/%h required=%h/%h",
                   wr_addr, reg_q[idx*8 +: 8], e.addr, e.data);
        end
      end
    end
    if (rd_sample) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_sample_no_expect actual=%h required=queued", sl_txdata);
      end else begin
        r = rd_q.pop_front();
        if (sl_txdata !== r) begin
          failures++;
          $display("FAIL rd_byte actual=%h required=%h", sl_txdata, r);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start(input logic r, input logic w);
    sl_r = r;
    sl_w = w;
    sl_start = 1'b1;
    tick(1);
    sl_start = 1'b0;
    tick(1);
  endtask

  task automatic bus_stop();
    sl_stop = 1'b1;
    tick(1);
    sl_stop = 1'b0;
    sl_r = 1'b0;
    sl_w = 1'b0;
    tick(1);
  endtask

  task automatic wr_byte(input logic [7:0] d);
    sl_rxdata = d;
    tick(2);
    sl_ack = 1'b1;
    tick(2);
    sl_ack = 1'b0;
    tick(2);
  endtask

  task automatic rd_byte(input logic [7:0] exp);
    rd_q.push_back(exp);
    rd_sample = 1'b1;
    tick(1);
    rd_sample = 1'b0;
    sl_ack = 1'b1;
    tick(2);
    sl_ack = 1'b0;
    tick(2);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    sl_start = 1'b0; sl_stop = 1'b0; sl_ack = 1'b0;
    sl_r = 1'b0; sl_w = 1'b0; sl_rxdata = 8'h00;
    ro_data = 32'h0;
    tick(3);
    rst = 1'b0;
    tick(2);

    check("rst_reg_q",   reg_q,     32'h0000_0605);
    check("rst_txdata",  sl_txdata, 32'h05);
    check("rst_err_cnt", err_cnt,   32'h0);
    check("rst_wr_stb",  wr_stb,    32'h0);
    check("rst_wr_addr", wr_addr,   32'h0);

    // Repeated-start read from pointer 2
    bus_start(1'b0, 1'b1);
    wr_byte(8'h02);
    bus_start(1'b1, 1'b0);
`ifdef I2C_REG_AUTOINC_EN
    rd_byte(8'h00); rd_byte(8'h00); rd_byte(8'h05);
`else
    rd_byte(8'h00); rd_byte(8'h00); rd_byte(8'h00);
`endif
    bus_stop();

    // Current-address read: pointer survives STOP
    bus_start(1'b1, 1'b0);
`ifdef I2C_REG_AUTOINC_EN
    rd_byte(8'h06);
`else
    rd_byte(8'h00);
`endif
    bus_stop();

    bus_start(1'b0, 1'b1);
    wr_byte(8'h00);
    bus_start(1'b1, 1'b0);
    rd_byte(8'h05);
    bus_stop();

    // Pointer set plus single write
    bus_start(1'b0, 1'b1);
    wr_byte(8'h01);
    push_wr(8'h01, 8'hA5);
    wr_byte(8'hA5);
    bus_stop();
    check("wr1_reg_q",   reg_q,   32'h0000_A505);
    check("wr1_wr_addr", wr_addr, 32'h01);

    // Burst write across the wrap point
    bus_start(1'b0, 1'b1);
    wr_byte(8'h03);
`ifdef I2C_REG_AUTOINC_EN
    push_wr(8'h03, 8'h11); wr_byte(8'h11);
    push_wr(8'h00, 8'h22); wr_byte(8'h22);
`else
    push_wr(8'h03, 8'h11); wr_byte(8'h11);
    push_wr(8'h03, 8'h22); wr_byte(8'h22);
`endif
    bus_stop();
`ifdef I2C_REG_AUTOINC_EN
    check("burst_reg_q",   reg_q,   32'h1100_A522);
    check("burst_wr_addr", wr_addr, 32'h00);
`else
    check("burst_reg_q",   reg_q,   32'h2200_A505);
    check("burst_wr_addr", wr_addr, 32'h03);
`endif

    // Read-only register and out-of-range pointer
    ro_data = 32'h003C_0000;
    tick(1);
    bus_start(1'b0, 1'b1);
    wr_byte(8'h02);
    wr_byte(8'h77);
    bus_stop();
    check("ro_err_cnt", err_cnt, 32'h1);
`ifdef I2C_REG_AUTOINC_EN
    check("ro_reg_q",   reg_q,   32'h113C_A522);
    check("ro_wr_addr", wr_addr, 32'h00);
`else
    check("ro_reg_q",   reg_q,   32'h223C_A505);
    check("ro_wr_addr", wr_addr, 32'h03);
`endif

    bus_start(1'b0, 1'b1);
    wr_byte(8'h09);
    bus_start(1'b1, 1'b0);
    rd_byte(8'hFF);
    bus_stop();

    bus_start(1'b0, 1'b1);
    wr_byte(8'h02);
    bus_start(1'b1, 1'b0);
    rd_byte(8'h3C);
    bus_stop();

    // Error counter saturates at all-ones (2 bits here)
    bus_start(1'b0, 1'b1); wr_byte(8'h09); wr_byte(8'h55); bus_stop();
    check("err_cnt_2", err_cnt, 32'h2);
    bus_start(1'b0, 1'b1); wr_byte(8'h09); wr_byte(8'h55); bus_stop();
    check("err_cnt_3", err_cnt, 32'h3);
    bus_start(1'b0, 1'b1); wr_byte(8'h09); wr_byte(8'h55); bus_stop();
    check("err_cnt_sat", err_cnt, 32'h3);

    // Reset between pointer byte and data byte
    bus_start(1'b0, 1'b1);
    wr_byte(8'h01);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("mid_rst_reg_q",   reg_q,     32'h003C_0605);
    check("mid_rst_txdata",  sl_txdata, 32'h05);
    check("mid_rst_err_cnt", err_cnt,   32'h0);
    check("mid_rst_wr_addr", wr_addr,   32'h0);
    wr_byte(8'hA5);
    tick(3);
    check("mid_rst_no_write", reg_q, 32'h003C_0605);
    bus_stop();

    tick(4);
    check("wr_q_drained", wr_q.size(), 32'd0);
    check("rd_q_drained", rd_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_reg_bank.md
Name: i2c_reg_bank

Overview:
- Parametrised register bank behind the byte-level i2c_slave; replaces the fixed 4-register model used in the SFP test environment.
- Decodes the byte-complete handshake from i2c_slave (ack, r, w, rxdata/txdata) into pointer set, burst writes and burst reads.
- Supports NUM_REGS registers with per-register read-only masking, reset values, auto-increment and an error counter.
- Sits between i2c_slave and SFP management logic, which consumes reg_q and wr_stb.

Parameters:
NUM_REGS, 4, register count, 1..256
RESET_VALUES, {8'd0,8'd0,8'd6,8'd5}, packed NUM_REGS*8 reset values, reg0 in LSBs
RO_MASK, 4'b0000, NUM_REGS bits; bit i=1 makes reg i read-only, sourced from ro_data
ERR_W, 8, error counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sl_start  in  1  one-cycle pulse on START or repeated START
sl_stop  in  1  one-cycle pulse on STOP
sl_ack  in  1  level; high during ACK slot of each data byte (slave address byte excluded)
sl_r  in  1  current transfer is read
sl_w  in  1  current transfer is write
sl_rxdata  in  8  byte received from master
sl_txdata  out  8  byte presented to master for reads
ro_data  in  NUM_REGS*8  live values for read-only registers
reg_q  out  NUM_REGS*8  current register contents (RO entries mirror ro_data)
wr_stb  out  1  one-cycle pulse per accepted write
wr_addr  out  8  register index of last accepted write
err_cnt  out  ERR_W  saturating count of rejected writes

Behaviour:
- Byte event: evt = sl_ack & ~ack_d; ack_d is a registered copy of sl_ack, reset 0.
- FSM states: IDLE, SEL, WDATA, RDATA. Reset state is IDLE.
- Any state, sl_start: go to SEL. Start takes priority over evt in the same cycle; that evt is dropped.
- Any state, sl_stop: go to IDLE. ptr is retained, giving EEPROM-style current-address reads. Stop beats start and evt.
- SEL, evt with sl_w: ptr <= sl_rxdata; go to WDATA. No register write.
- SEL, evt with sl_r: byte sent was reg[ptr]; ptr advances; go to RDATA.
- WDATA, evt: if ptr<NUM_REGS and !RO_MASK[ptr], then reg[ptr] <= sl_rxdata, wr_stb=1 for the next cycle, wr_addr <= ptr. Otherwise err_cnt++ (saturating at all-ones), no wr_stb. ptr advances in both cases.
- RDATA, evt: ptr advances.
- IDLE, evt: ignored.
- Pointer advance: ptr <= (ptr==NUM_REGS-1) ? 0 : ptr+1. Out-of-range ptr (>=NUM_REGS) increments to 255, then wraps to 0.
- sl_txdata is registered, updated every cycle:
  - RW reg: reg[ptr]
  - RO reg: ro_data[ptr]
  - out of range: 8'hFF
  - latency: 1 clk after a ptr change; i2c_slave samples it at least 2 clk after ack falls.
- Reset values:
  - reg[i] = RESET_VALUES[i]
  - ptr = 0, sl_txdata = reg[0] reset value (ro_data not yet valid, so RO reg0 drives 8'h00)
  - wr_stb 0, wr_addr 0, err_cnt 0
- Reset mid-transaction: state IDLE, all registers return to reset values, any pending write is lost.
- sl_r and sl_w both high at the evt: treated as write.

Optional Feature:
- Macro I2C_REG_AUTOINC_EN.
- Defined: pointer advances as above, allowing burst reads/writes.
- Undefined: ptr changes only on the pointer byte in SEL. Repeated writes hit the same register, each with wr_stb; repeated reads return the same register.

Decomposition:
- Package i2c_reg_pkg:
  - state enum i2c_reg_state_e {IDLE, SEL, WDATA, RDATA}
  - PTR_W=8
  - OOR_DATA=8'hFF
  - function next_ptr(ptr, num_regs)
- Sub-module i2c_reg_ptr: pointer register, wrap rule and AUTOINC gating; inputs load/advance, output ptr and in_range.

Test Plan:
- Reset defaults: after rst, reg_q = {0,0,6,5}, sl_txdata=5, err_cnt=0.
- Pointer set plus write: start, w, bytes 8'h01, 8'hA5 -> reg1=A5, wr_stb one pulse, wr_addr=1.
- Burst write wrap: pointer 3, data 11,22 -> reg3=11, reg0=22, two wr_stb pulses. Without AUTOINC_EN: reg3=22, reg0 unchanged.
- Repeated-start read: write ptr 2, start, r, 3 reads -> txdata 00,00,05 (reg2, reg3, reg0).
- RO and out-of-range: RO_MASK=4'b0100, ro_data[2]=3C. Write 77 to reg2 -> unchanged, err_cnt=1. Read ptr 9 -> FF. Read ptr 2 -> 3C.
- Mid-write reset: assert rst between pointer byte and data byte -> IDLE, reg_q back to defaults, no wr_stb.
